seven_segment_scan_controller: RTL and testbench

SEVEN_SEGMENT_SCAN_CONTROLLER -- requirements
Module: seven_segment_scan_controller

---
 rtl/seven_segment_scan_controller.sv | 156 +++++++++++++++
 tb/tb_seven_segment_scan_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_controller.sv
// Multiplexed seven-segment scan driver: double-buffered display registers that are swapped
// only on frame boundaries, PWM brightness, per-digit blink, registered low-active drives.
module seven_segment_scan_controller #(
   parameter int NUM_DIGITS   = 8,
   parameter int REFRESH_DIV  = 100000,
   parameter int BRIGHT_W     = 4,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                    system_clock,
   input  logic                    cpu_rst,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic [NUM_DIGITS-1:0]   blink_in,
   input  logic [BRIGHT_W-1:0]     brightness,
   input  logic                    load,
   output logic                    update_pending,
   output logic                    frame_done,
   output logic [NUM_DIGITS-1:0]   anode_out,
   output logic [6:0]              cathodes_out,
   output logic                    dp_out
);

   localparam int PRE_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PRE_W-1:0]        pre_cnt;
   logic [IDX_W-1:0]        idx;
   logic [BRIGHT_W-1:0]     pwm_cnt;
   logic [BLK_W-1:0]        blink_cnt;
   logic                    blink_phase;
   logic                    tick;
   logic                    boundary;

   logic [4*NUM_DIGITS-1:0] sh_digits, act_digits;
   logic [NUM_DIGITS-1:0]   sh_dp, act_dp;
   logic [NUM_DIGITS-1:0]   sh_blank, act_blank;
   logic [NUM_DIGITS-1:0]   sh_blink, act_blink;
   logic [BRIGHT_W-1:0]     sh_bright, act_bright;

   logic [NUM_DIGITS-1:0]   anode_nxt;
   logic [6:0]              cath_nxt;
   logic                    dp_nxt;
   logic                    sel_dark;
   logic [3:0]              sel_nibble;

   function automatic logic [6:0] hex_decode(input logic [3:0] n);
      case (n)
         4'h0: hex_decode = 7'b1000000;
         4'h1: hex_decode = 7'b1111001;
         4'h2: hex_decode = 7'b0100100;
         4'h3: hex_decode = 7'b0110000;
         4'h4: hex_decode = 7'b0011001;
         4'h5: hex_decode = 7'b0010010;
         4'h6: hex_decode = 7'b0000010;
         4'h7: hex_decode = 7'b1111000;
         4'h8: hex_decode = 7'b0000000;
         4'h9: hex_decode = 7'b0010000;
         4'hA: hex_decode = 7'b0001000;
         4'hB: hex_decode = 7'b0000011;
         4'hC: hex_decode = 7'b1000110;
         4'hD: hex_decode = 7'b0100001;
         4'hE: hex_decode = 7'b0000110;
         default: hex_decode = 7'b0001110;
      endcase
   endfunction

   assign tick       = (pre_cnt == PRE_W'(REFRESH_DIV - 1));
   assign boundary   = tick && (idx == IDX_W'(NUM_DIGITS - 1));
   assign frame_done = boundary;

   always_ff @(posedge system_clock) begin
      if (cpu_rst) begin
         pre_cnt     <= '0;
         idx         <= '0;
         pwm_cnt     <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
         if (tick)
            idx <= boundary ? '0 : idx + 1'b1;
         if (boundary) begin
            if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

   // A load on the boundary cycle only refills the shadow; the swap uses the pre-load shadow.
   always_ff @(posedge system_clock) begin
      if (cpu_rst) begin
         sh_digits      <= '0;
         sh_dp          <= '0;
         sh_blank       <= '1;
         sh_blink       <= '0;
         sh_bright      <= '1;
         act_digits     <= '0;
         act_dp         <= '0;
         act_blank      <= '1;
         act_blink      <= '0;
         act_bright     <= '1;
         update_pending <= 1'b0;
      end else begin
         if (boundary && update_pending) begin
            act_digits <= sh_digits;
            act_dp     <= sh_dp;
            act_blank  <= sh_blank;
            act_blink  <= sh_blink;
            act_bright <= sh_bright;
         end
         if (load) begin
            sh_digits      <= digits_in;
            sh_dp          <= dp_in;
            sh_blank       <= blank_in;
            sh_blink       <= blink_in;
            sh_bright      <= brightness;
            update_pending <= 1'b1;
         end else if (boundary) begin
            update_pending <= 1'b0;
         end
      end
   end

   always_comb begin
      anode_nxt  = '1;
      cath_nxt   = 7'h7F;
      dp_nxt     = 1'b1;
      sel_nibble = act_digits[4*int'(idx) +: 4];
      sel_dark   = act_blank[idx] | (act_blink[idx] & blink_phase) | (pwm_cnt > act_bright);
      if (!sel_dark) begin
         anode_nxt = ~(NUM_DIGITS'(1) << idx);
         cath_nxt  = hex_decode(sel_nibble);
         dp_nxt    = ~act_dp[idx];
      end
   end

   always_ff @(posedge system_clock) begin
      if (cpu_rst) begin
         anode_out    <= '1;
         cathodes_out <= 7'h7F;
         dp_out       <= 1'b1;
      end else begin
         anode_out    <= anode_nxt;
         cathodes_out <= cath_nxt;
         dp_out       <= dp_nxt;
      end
   end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed bench for the scan controller with a 4-digit, 4-cycle-slot, 2-bit PWM, 2-frame blink setup.
module tb_seven_segment_scan_controller;

   logic        system_clock = 1'b0;
   logic        cpu_rst = 1'b1;
   logic [15:0] digits_in = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  blank_in = '0;
   logic [3:0]  blink_in = '0;
   logic [1:0]  brightness = '0;
   logic        load = 1'b0;
   logic        update_pending;
   logic        frame_done;
   logic [3:0]  anode_out;
   logic [6:0]  cathodes_out;
   logic        dp_out;

   int vectors = 0;
   int errors  = 0;

   seven_segment_scan_controller #(
      .NUM_DIGITS(4), .REFRESH_DIV(4), .BRIGHT_W(2), .BLINK_FRAMES(2)
   ) dut (
      .system_clock(system_clock),
      .cpu_rst(cpu_rst),
      .digits_in(digits_in),
      .dp_in(dp_in),
      .blank_in(blank_in),
      .blink_in(blink_in),
      .brightness(brightness),
      .load(load),
      .update_pending(update_pending),
      .frame_done(frame_done),
      .anode_out(anode_out),
      .cathodes_out(cathodes_out),
      .dp_out(dp_out)
   );

   always #5 system_clock = ~system_clock;

   typedef struct {
      logic [15:0]     digits;
      logic [3:0]      dp;
      logic [3:0]      blank;
      logic [1:0]      bright;
      logic [3:0][6:0] cath;     // expected decode per digit, [k] = digit k
      logic [3:0]      dp_exp;   // expected dp_out per digit when lit
      logic [3:0]      lit;      // digits not blanked
      logic [3:0]      pwm_on;   // PWM phases (0..3) in which the slot is lit
   } vec_t;

   vec_t       vecs [4];
   logic [3:0] anode_sel [4];

   task automatic step();
      @(posedge system_clock);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_out(input logic [3:0] an, input logic [6:0] ca, input logic dp);
      chk("anode", anode_out, an);
      chk("cathodes", cathodes_out, ca);
      chk("dp", dp_out, dp);
      chk("anode_onehot", ($countones(~anode_out) <= 1), 1);
   endtask

   task automatic wait_fd();
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         if (frame_done) seen = 1'b1;
      end
      chk("frame_done_seen", seen, 1'b1);
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                          input logic [3:0] bk, input logic [1:0] br);
      digits_in = d; dp_in = dp; blank_in = bl; blink_in = bk; brightness = br;
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   initial begin
      anode_sel[0] = 4'b1110; anode_sel[1] = 4'b1101;
      anode_sel[2] = 4'b1011; anode_sel[3] = 4'b0111;

      vecs[0] = '{16'h1234, 4'b0000, 4'b0000, 2'd3,
                  {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111, 4'b1111, 4'b1111};
      vecs[1] = '{16'h89AB, 4'b0101, 4'b0000, 2'd0,
                  {7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011}, 4'b1010, 4'b1111, 4'b0001};
      vecs[2] = '{16'hFEDC, 4'b1111, 4'b0110, 2'd1,
                  {7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110}, 4'b0000, 4'b1001, 4'b0011};
      vecs[3] = '{16'h5670, 4'b0000, 4'b0000, 2'd2,
                  {7'b0010010, 7'b0000010, 7'b1111000, 7'b1000000}, 4'b1111, 4'b1111, 4'b0111};

      // reset with load held high: load must be ignored
      cpu_rst = 1'b1;
      load = 1'b1;
      repeat (3) step();
      chk_out(4'hF, 7'h7F, 1'b1);
      chk("rst_pending", update_pending, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      load = 1'b0;
      cpu_rst = 1'b0;

      // table: each record loaded mid-frame, then one whole frame checked after the swap
      foreach (vecs[v]) begin
         do_load(vecs[v].digits, vecs[v].dp, vecs[v].blank, 4'b0000, vecs[v].bright);
         chk("pending_after_load", update_pending, 1'b1);
         wait_fd();
         step();
         chk("pending_after_swap", update_pending, 1'b0);
         chk("frame_done_width", frame_done, 1'b0);
         for (int j = 0; j < 16; j++) begin
            step();
            if (vecs[v].lit[j / 4] && vecs[v].pwm_on[j % 4])
               chk_out(anode_sel[j / 4], vecs[v].cath[j / 4], vecs[v].dp_exp[j / 4]);
            else
               chk_out(4'hF, 7'h7F, 1'b1);
         end
      end

      // load at cycle 2 of a frame: old display held until the boundary
      step(); step();
      do_load(16'h1111, 4'b0000, 4'b0000, 4'b0000, 2'd3);
      chk_out(4'b1110, 7'b1000000, 1'b1);
      chk("hold_pending", update_pending, 1'b1);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 40 && !seen; i++) begin
            step();
            chk("hold_pending", update_pending, 1'b1);
            if (frame_done) seen = 1'b1;
         end
         chk("frame_done_seen", seen, 1'b1);
      end
      step();
      chk("hold_cleared", update_pending, 1'b0);
      step();
      chk_out(4'b1110, 7'b1111001, 1'b1);

      // two loads in one frame: last write wins, one boundary clears pending
      do_load(16'hAAAA, 4'b0000, 4'b0000, 4'b0000, 2'd3);
      do_load(16'h5555, 4'b0000, 4'b0000, 4'b0000, 2'd3);
      chk("double_pending", update_pending, 1'b1);
      wait_fd();
      step();
      chk("double_cleared", update_pending, 1'b0);
      for (int j = 0; j < 16; j++) begin
         step();
         chk_out(anode_sel[j / 4], 7'b0010010, 1'b1);
      end

      // load on the boundary cycle: applied one frame later
      wait_fd();
      do_load(16'h0000, 4'b0000, 4'b0000, 4'b0000, 2'd3);
      chk("bnd_pending", update_pending, 1'b1);
      step();
      chk_out(4'b1110, 7'b0010010, 1'b1);
      wait_fd();
      step();
      chk("bnd_cleared", update_pending, 1'b0);
      step();
      chk_out(4'b1110, 7'b1000000, 1'b1);

      // reset mid-slot with a pending load discards it and darkens the display
      do_load(16'h9999, 4'b0000, 4'b0000, 4'b0000, 2'd3);
      step();
      cpu_rst = 1'b1;
      step();
      chk_out(4'hF, 7'h7F, 1'b1);
      chk("rst_mid_pending", update_pending, 1'b0);
      chk("rst_mid_frame_done", frame_done, 1'b0);
      step();
      cpu_rst = 1'b0;
      for (int j = 0; j < 20; j++) begin
         step();
         chk("dark_anode", anode_out, 4'hF);
         chk("dark_pending", update_pending, 1'b0);
      end

      // blink on digit 0: swap lands with phase 1, so frames go dark,dark,lit,lit,dark,dark
      do_load(16'h1234, 4'b0000, 4'b0000, 4'b0001, 2'd3);
      wait_fd();
      step();
      begin
         logic [5:0] blink_lit;
         blink_lit = 6'b001100;
         for (int f = 0; f < 6; f++) begin
            for (int j = 0; j < 16; j++) begin
               step();
               if (j / 4 != 0)
                  chk_out(anode_sel[j / 4], vecs[0].cath[j / 4], 1'b1);
               else if (blink_lit[f])
                  chk_out(4'b1110, 7'b0011001, 1'b1);
               else
                  chk_out(4'hF, 7'h7F, 1'b1);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
